fetch_pc: RTL
=============

Name: fetch_pc

Overview:
- Program-counter and instruction-fetch stage of the MIPS core; sits directly upstream of the PC+4 adder.
- Drives the current PC into the adder (`in_add_1`, with `in_add_2` tied to 4) and takes the adder result back as the sequential next PC.
- Issues one-outstanding instruction-memory requests over a req/ack handshake and presents fetched instructions to decode over a valid/ready handshake.
- Handles stall and branch/jump redirect, including abandoning an in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded by reset.
- ADDR_W, 32, PC/address width.

Ports:
- in_clk  input  1  clock; all state updates on rising edge
- in_rst_n  input  1  synchronous, active-low reset
- in_pc_plus4  input  ADDR_W  adder out_add (= out_pc + 4)
- out_pc  output  ADDR_W  current PC register; to adder in_add_1
- in_stall  input  1  hazard stall; blocks new fetch issue
- in_redirect  input  1  branch/jump taken; flush and reload PC
- in_redirect_pc  input  ADDR_W  redirect target
- out_imem_req  output  1  instruction memory request
- out_imem_addr  output  ADDR_W  request address; stable while req pending
- in_imem_ack  input  1  memory response valid (same cycle as req or later)
- in_imem_rdata  input  32  instruction word
- out_valid  output  1  out_instr valid to decode
- in_ready  input  1  decode accepts
- out_instr  output  32  fetched instruction
- out_instr_pc  output  ADDR_W  PC of out_instr
- out_misalign  output  1  1-cycle pulse: redirect target had [1:0]!=0

Behaviour:
- Clock and reset: one clock, in_clk. Reset is synchronous and active-low on in_rst_n; priority is reset > redirect > ack > stall.
- Reset values:
  - out_pc = out_imem_addr = RESET_PC
  - out_valid = out_misalign = 0
  - out_instr = out_instr_pc = 0
  - state = FETCH
  - out_imem_req forced 0 while in_rst_n=0
  - Memory shares the reset, so reset mid-request discards it silently.
- Definitions:
  - slot_free = !out_valid || in_ready.
  - Accepted ack means the ack's data is captured: out_instr <= in_imem_rdata, out_instr_pc <= request address, out_valid <= 1, out_pc <= in_pc_plus4.
- FETCH (no outstanding request):
  - out_imem_req = slot_free && !in_stall && !in_redirect; out_imem_addr = out_pc (combinational).
  - req && ack in the same cycle: accept.
  - req && !ack: latch the request address, go to WAIT.
- WAIT (request outstanding):
  - req held at 1 with the latched address.
  - ack: accept, go to FETCH.
  - The slot is guaranteed empty at issue, so no overflow is possible.
- DROP (abandoned request outstanding):
  - req held at 1 with the old address.
  - ack: discard data, go to FETCH.
- Redirect, any state:
  - out_pc <= {in_redirect_pc[ADDR_W-1:2], 2'b00}.
  - out_valid <= 0, flushing the held instruction.
  - Any ack in the same cycle is discarded.
  - WAIT without ack goes to DROP; WAIT with ack goes to FETCH; DROP stays DROP.
- Misalignment: out_misalign <= |in_redirect_pc[1:0] when in_redirect; otherwise 0.
- Stall: gates new issue only; pending WAIT/DROP requests complete normally.
- Output handshake: out_valid && in_ready consumes; out_valid clears unless an ack is accepted the same cycle. While out_valid && !in_ready, out_instr and out_instr_pc are held stable.
- Wrap: PC 32'hFFFF_FFFC advances to 32'h0000_0000 (adder wraps modulo 2^32).
- Latency and throughput:
  - With a zero-wait memory, the first instruction is valid 1 cycle after reset release (request in cycle 0, out_valid in cycle 1).
  - Sustained rate is 1 instruction/cycle.

Decomposition:
- mips_fetch_pkg holds:
  - fetch_state_t enum {FETCH, WAIT, DROP}
  - INSTR_W=32, PC_INC=4, NOP_INSTR=32'h0000_0000
- No sub-module inside fetch_pc. The existing adder is instantiated beside fetch_pc at core top level, wired out_pc -> in_add_1, 4 -> in_add_2, out_add -> in_pc_plus4. The bench instantiates both.

Test Plan:
- Reset release, zero-wait memory returning rdata=addr, in_ready=1 -> out_instr_pc 0x0,0x4,0x8 with out_valid each cycle; out_pc tracks +4.
- Memory ack delayed 3 cycles -> req/addr stable 3 cycles; one instruction delivered per ack, never duplicated.
- in_ready=0 for 4 cycles holding instr at PC 0x8 -> out_instr stable, no new req; resumes at 0xC after ready.
- Redirect to 0x100 while WAIT on 0x10 -> ack for 0x10 discarded; next valid out_instr_pc=0x100; redirect to 0x203 -> PC=0x200, out_misalign pulses 1 cycle.
- in_stall=1 for 2 cycles in FETCH -> no req; PC held.
- PC forced to 0xFFFF_FFFC -> next out_instr_pc=0x0.
- Reset asserted mid-WAIT -> all outputs return to reset values next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_fetch_pkg;
    localparam int                 INSTR_W   = 32;
    localparam logic [31:0]        PC_INC    = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DROP
    } fetch_state_t;
endpackage

// File: rtl/mips_adder.sv
// PC incrementer beside fetch_pc: out_add = in_add_1 + in_add_2, modulo 2^ADDR_W.
// Purely combinational, no backpressure.
module mips_adder #(
    parameter int ADDR_W = 32
)(
    input  logic [ADDR_W-1:0] in_add_1,
    input  logic [ADDR_W-1:0] in_add_2,
    output logic [ADDR_W-1:0] out_add
);
    assign out_add = in_add_1 + in_add_2;
endmodule

// File: rtl/fetch_pc.sv
// PC register + one-outstanding imem fetch; zero-wait memory gives 1 instr/cycle, valid 1 cycle after req.
// Backpressure: no new request issues unless the output slot is free and no stall/redirect is present.
module fetch_pc
    import mips_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic               in_clk,
    input  logic               in_rst_n,
    input  logic [ADDR_W-1:0]  in_pc_plus4,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               in_stall,
    input  logic               in_redirect,
    input  logic [ADDR_W-1:0]  in_redirect_pc,
    output logic               out_imem_req,
    output logic [ADDR_W-1:0]  out_imem_addr,
    input  logic               in_imem_ack,
    input  logic [INSTR_W-1:0] in_imem_rdata,
    output logic               out_valid,
    input  logic               in_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_instr_pc,
    output logic               out_misalign
);
    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  r_req_addr;
    logic               r_valid;
    logic               r_misalign;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_instr_pc;

    logic               w_slot_free;
    logic               w_req;
    logic               w_accept;
    logic               w_latch;
    logic [ADDR_W-1:0]  w_addr;
    logic [ADDR_W-1:0]  w_redir_pc;

    assign w_slot_free = !r_valid || in_ready;
    assign w_redir_pc  = {in_redirect_pc[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_addr      = r_req_addr;
        w_accept    = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            FETCH: begin
                w_addr = r_pc;
                w_req  = w_slot_free && !in_stall && !in_redirect;
                if (w_req) begin
                    if (in_imem_ack) begin
                        w_accept = 1'b1;
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (in_imem_ack) begin
                    // A redirect in the ack cycle throws the returning word away.
                    w_accept    = !in_redirect;
                    w_state_nxt = FETCH;
                end else if (in_redirect) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                w_req = 1'b1;
                if (in_imem_ack) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_instr_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= in_redirect && (|in_redirect_pc[1:0]);
            if (w_latch) begin
                r_req_addr <= r_pc;
            end
            if (in_redirect) begin
                r_pc    <= w_redir_pc;
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_instr    <= in_imem_rdata;
                r_instr_pc <= w_addr;
                r_valid    <= 1'b1;
                r_pc       <= in_pc_plus4;
            end else if (r_valid && in_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Memory shares reset, so no request may be visible while it is held.
    assign out_imem_req  = w_req && in_rst_n;
    assign out_imem_addr = w_addr;
    assign out_pc        = r_pc;
    assign out_valid     = r_valid;
    assign out_instr     = r_instr;
    assign out_instr_pc  = r_instr_pc;
    assign out_misalign  = r_misalign;
endmodule
